// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package seven_seg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } scan_state_t;

   localparam logic [6:0] SEG_CODE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   localparam logic [6:0] SEG_OFF = 7'h00;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_seg7.sv
// Nibble to seven-segment decoder with optional blanking.
// Output polarity follows the pin drive level.
import seven_seg_pkg::*;

module hex_to_seg7 #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   // look up the code and flip it to pin polarity
   always_comb begin
      seg = (blank ? SEG_OFF : SEG_CODE[nibble]) ^ {7{ACTIVE_LOW}};
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with blanking gaps,
// frame-aligned value updates and leading-zero suppression.
import seven_seg_pkg::*;

module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter bit ACTIVE_LOW   = 1'b1,
   localparam int IDX_W = idx_width(NUM_DIGITS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    value_valid,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_suppress,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_done
);

   localparam int VW    = 4*NUM_DIGITS;
   localparam int CNT_W = $clog2(PRESCALE);

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(PRESCALE-1);
   localparam logic [CNT_W-1:0] BLANK_LAST =
      CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES-1 : 0);
   localparam logic [IDX_W-1:0] DIG_LAST =
      IDX_W'(NUM_DIGITS-1);
   localparam scan_state_t SLOT_START =
      (BLANK_CYCLES > 0) ? BLANK : DRIVE;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF =
      {NUM_DIGITS{ACTIVE_LOW}};

   scan_state_t             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [VW-1:0]           shadow_val_q;
   logic [NUM_DIGITS-1:0]   shadow_dp_q;
   logic [VW-1:0]           disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;

   logic                    drive;
   logic                    lz_blank;
   logic [3:0]              nib;
   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   sel_d;
   logic                    dp_d;
   logic                    fd_d;

   // state, slot counter and digit index registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // slot sequencing and frame-aligned display reload
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d    = SLOT_START;
               cnt_d      = '0;
               idx_d      = '0;
               disp_val_d = shadow_val_q;
               disp_dp_d  = shadow_dp_q;
            end
            BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST)
                  state_d = DRIVE;
            end
            DRIVE: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = SLOT_START;
                  if (idx_q == DIG_LAST) begin
                     idx_d = '0;
                     if (value_valid) begin
                        disp_val_d = value_in;
                        disp_dp_d  = dp_in;
                     end else begin
                        disp_val_d = shadow_val_q;
                        disp_dp_d  = shadow_dp_q;
                     end
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // output values for the upcoming cycle
   always_comb begin
      drive    = (state_d == DRIVE);
      nib      = disp_val_d[{idx_d, 2'b00} +: 4];
      lz_blank = lz_suppress && (idx_d != '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IDX_W'(i) >= idx_d &&
             disp_val_d[4*i +: 4] != 4'h0)
            lz_blank = 1'b0;
      end
      sel_d = SEL_OFF;
      dp_d  = ACTIVE_LOW;
      if (drive) begin
         sel_d[idx_d] = ~ACTIVE_LOW;
         dp_d         = disp_dp_d[idx_d] ^ ACTIVE_LOW;
      end
      fd_d = drive && (cnt_d == CNT_LAST) &&
             (idx_d == DIG_LAST);
   end

   hex_to_seg7 #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_dec (
      .nibble (nib),
      .blank  (!drive || lz_blank),
      .seg    (seg_d)
   );

   // shadow, display and registered pin outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         seg_out      <= {7{ACTIVE_LOW}};
         dp_out       <= ACTIVE_LOW;
         digit_sel    <= SEL_OFF;
         digit_idx    <= '0;
         frame_done   <= 1'b0;
      end else begin
         if (value_valid) begin
            shadow_val_q <= value_in;
            shadow_dp_q  <= dp_in;
         end
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         seg_out    <= seg_d;
         dp_out     <= dp_d;
         digit_sel  <= sel_d;
         digit_idx  <= idx_d;
         frame_done <= fd_d;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus
// randomized traffic against a time-based display model.
module tb_seven_seg_scan_ctrl;

   localparam int N = 4;
   localparam int P = 8;
   localparam int B = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] value_in = '0;
   logic        value_valid = 1'b0;
   logic [3:0]  dp_in = '0;
   logic        lz_suppress = 1'b0;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  digit_sel;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   bit          m_run = 1'b0;
   int          m_t = 0;
   logic [15:0] m_disp = '0;
   logic [15:0] m_shadow = '0;
   logic [3:0]  m_dp = '0;
   logic [3:0]  m_sdp = '0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (N),
      .PRESCALE     (P),
      .BLANK_CYCLES (B),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .value_in    (value_in),
      .value_valid (value_valid),
      .dp_in       (dp_in),
      .lz_suppress (lz_suppress),
      .seg_out     (seg_out),
      .dp_out      (dp_out),
      .digit_sel   (digit_sel),
      .digit_idx   (digit_idx),
      .frame_done  (frame_done)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_outputs(output logic [6:0] s,
                                output logic d,
                                output logic [3:0] sel,
                                output logic [1:0] ix,
                                output logic f);
      int ph;
      int dg;
      logic [3:0] nb;
      s = 7'h7F; d = 1'b1; sel = 4'hF;
      ix = 2'd0; f = 1'b0;
      if (m_run) begin
         ph = m_t % P;
         dg = (m_t / P) % N;
         ix = 2'(dg);
         f = (ph == P-1) && (dg == N-1);
         if (ph >= B) begin
            sel = ~(4'b0001 << dg);
            d = ~m_dp[dg];
            nb = m_disp[4*dg +: 4];
            if (!(lz_suppress && dg != 0 &&
                  (m_disp >> (4*dg)) == 16'h0))
               s = ~seg_tab[nb];
         end
      end
   endtask

   task automatic check_all();
      logic [6:0] es;
      logic ed;
      logic [3:0] esel;
      logic [1:0] eix;
      logic ef;
      model_outputs(es, ed, esel, eix, ef);
      check("seg_out", 32'(seg_out), 32'(es));
      check("dp_out", 32'(dp_out), 32'(ed));
      check("digit_sel", 32'(digit_sel), 32'(esel));
      check("digit_idx", 32'(digit_idx), 32'(eix));
      check("frame_done", 32'(frame_done), 32'(ef));
   endtask

   task automatic step();
      bit wrap;
      @(posedge clk);
      wrap = m_run && (m_t % (P*N)) == P*N-1;
      if (!enable) begin
         m_run = 1'b0;
         m_t = 0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_t = 0;
         m_disp = m_shadow;
         m_dp = m_sdp;
      end else begin
         if (wrap) begin
            m_disp = value_valid ? value_in : m_shadow;
            m_dp = value_valid ? dp_in : m_sdp;
         end
         m_t++;
      end
      if (value_valid) begin
         m_shadow = value_in;
         m_sdp = dp_in;
      end
      #1;
      check_all();
      value_valid = 1'b0;
   endtask

   task automatic run_to(input int dg, input int ph);
      int n;
      n = 0;
      while (!(m_run && m_t % P == ph &&
               (m_t / P) % N == dg) && n < 100) begin
         step();
         n++;
      end
      check("run_to_bound", 32'(n < 100), 32'd1);
   endtask

   initial begin
      int fcount;
      #12;
      check("rst_seg", 32'(seg_out), 32'h7F);
      check("rst_sel", 32'(digit_sel), 32'hF);
      check("rst_dp", 32'(dp_out), 32'h1);
      check("rst_fd", 32'(frame_done), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step();

      enable = 1'b1;
      step();
      check("first_blank_sel", 32'(digit_sel), 32'hF);
      run_to(0, 2);
      check("zero_d0_seg", 32'(seg_out), 32'h40);
      check("zero_d0_sel", 32'(digit_sel), 32'hE);
      run_to(3, 7);
      check("fd_pulse", 32'(frame_done), 32'h1);
      fcount = 0;
      for (int i = 0; i < 64; i++) begin
         step();
         if (frame_done) fcount++;
      end
      check("fd_per_64", 32'(fcount), 32'd2);

      run_to(1, 4);
      value_in = 16'h12AF;
      value_valid = 1'b1;
      step();
      run_to(2, 4);
      check("tearfree_d2", 32'(seg_out), 32'h40);
      run_to(0, 3);
      check("12AF_d0", 32'(seg_out), 32'h0E);
      run_to(1, 3);
      check("12AF_d1", 32'(seg_out), 32'h08);
      run_to(2, 3);
      check("12AF_d2", 32'(seg_out), 32'h24);
      run_to(3, 3);
      check("12AF_d3", 32'(seg_out), 32'h79);

      run_to(3, 7);
      value_in = 16'h0007;
      value_valid = 1'b1;
      step();
      run_to(0, 3);
      check("bypass_d0", 32'(seg_out), 32'h78);
      run_to(1, 3);
      check("bypass_d1", 32'(seg_out), 32'h40);

      lz_suppress = 1'b1;
      value_in = 16'h0050;
      dp_in = 4'b0100;
      value_valid = 1'b1;
      step();
      run_to(0, 3);
      check("lz_d0_seg", 32'(seg_out), 32'h40);
      run_to(1, 3);
      check("lz_d1_seg", 32'(seg_out), 32'h12);
      run_to(2, 3);
      check("lz_d2_seg", 32'(seg_out), 32'h7F);
      check("lz_d2_dp", 32'(dp_out), 32'h0);
      run_to(3, 3);
      check("lz_d3_seg", 32'(seg_out), 32'h7F);
      check("lz_d3_dp", 32'(dp_out), 32'h1);

      run_to(2, 4);
      enable = 1'b0;
      step();
      check("dis_sel", 32'(digit_sel), 32'hF);
      check("dis_seg", 32'(seg_out), 32'h7F);
      check("dis_idx", 32'(digit_idx), 32'h0);
      enable = 1'b1;
      step();
      check("reen_idx", 32'(digit_idx), 32'h0);
      check("reen_sel", 32'(digit_sel), 32'hF);
      run_to(0, 2);
      check("reen_d0_sel", 32'(digit_sel), 32'hE);

      value_in = 16'hBEEF;
      dp_in = 4'hF;
      value_valid = 1'b1;
      step();
      run_to(1, 5);
      #2;
      reset = 1'b1;
      #1;
      check("arst_seg", 32'(seg_out), 32'h7F);
      check("arst_sel", 32'(digit_sel), 32'hF);
      check("arst_dp", 32'(dp_out), 32'h1);
      m_run = 1'b0; m_t = 0;
      m_disp = '0; m_shadow = '0;
      m_dp = '0; m_sdp = '0;
      enable = 1'b0;
      lz_suppress = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
      step();
      run_to(0, 4);
      check("post_rst_d0", 32'(seg_out), 32'h40);
      check("post_rst_dp", 32'(dp_out), 32'h1);
      run_to(3, 4);
      check("post_rst_d3", 32'(seg_out), 32'h40);
      run_to(0, 4);
      check("post_rst_f2_d0", 32'(seg_out), 32'h40);

      for (int i = 0; i < 1500; i++) begin
         enable = ($urandom_range(0, 80) != 0);
         value_valid = ($urandom_range(0, 9) == 0);
         value_in = 16'($urandom) &
                    (16'hFFFF >> (4*$urandom_range(0, 3)));
         dp_in = 4'($urandom);
         if ($urandom_range(0, 99) == 0)
            lz_suppress = ~lz_suppress;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's common-anode seven-segment bank.
- Takes the 16-bit hex word written by software through the seven-seg PIO (out_port), plus per-digit decimal points.
- Sequences one digit at a time with a blanking gap between digits to suppress ghosting, and decodes hex to segments.
- Sits between the PIO output and the FPGA display pins; display updates are tear-free because new values are applied only at frame boundaries.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; value_in carries 4 bits per digit.
- PRESCALE, 50000: clk cycles per digit slot. Legal range is 2 or more.
- BLANK_CYCLES, 16: leading cycles of each slot with all digits off. Must be less than PRESCALE.
- ACTIVE_LOW, 1: 1 means seg_out, dp_out and digit_sel light a segment or digit when driven 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scanning on when 1
- value_in  in  4*NUM_DIGITS  hex digits; nibble i drives digit i, digit 0 is least significant
- value_valid  in  1  one-cycle strobe that captures value_in and dp_in into the shadow register
- dp_in  in  NUM_DIGITS  decimal-point request per digit
- lz_suppress  in  1  blank leading zeros when 1
- seg_out  out  7  segments {g,f,e,d,c,b,a}
- dp_out  out  1  decimal point of the active digit
- digit_sel  out  NUM_DIGITS  one-hot digit enable
- digit_idx  out  clog2(NUM_DIGITS)  index of the current slot
- frame_done  out  1  one-cycle pulse at the end of the last slot

Behaviour:
- Reset (async, active-high):
  - state=IDLE; slot counter=0; digit_idx=0; frame_done=0.
  - Shadow and display registers cleared to 0.
  - seg_out, dp_out and digit_sel at their OFF level (all 1s if ACTIVE_LOW, else all 0s).
- States:
  - IDLE: outputs OFF, counters held at 0. Moves to BLANK the cycle after enable=1 is sampled.
  - BLANK: digit_sel OFF, seg_out OFF. Lasts BLANK_CYCLES cycles, then DRIVE. If BLANK_CYCLES=0, skip directly to DRIVE.
  - DRIVE: digit_sel has bit digit_idx ON; seg_out = decode(display nibble digit_idx); dp_out = display dp bit. Lasts PRESCALE-BLANK_CYCLES cycles.
  - End of DRIVE: digit_idx increments and the state returns to BLANK. When digit_idx=NUM_DIGITS-1 it wraps to 0 and frame_done pulses for exactly that final DRIVE cycle.
- All outputs are registered; a state change is visible one cycle after its cause.
- enable deassert in any state: next cycle is IDLE with outputs OFF and counters cleared. Re-enable restarts at digit 0, BLANK.
- Value update rules:
  - value_valid loads the shadow register every time it is strobed; the last strobe wins.
  - The display register loads from the shadow on the frame-wrap cycle (the frame_done cycle).
  - If value_valid coincides with the wrap cycle, value_in/dp_in bypass straight into the display register.
  - On leaving IDLE, display is loaded from the shadow.
- Leading-zero suppression (lz_suppress=1):
  - Digit i is blanked (seg_out OFF) if its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - dp_out is still driven from dp_in, even on a blanked digit.
- Decode (active-high codes, inverted when ACTIVE_LOW):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- No simultaneous ON digits: digit_sel is never more than one-hot in any cycle.

Decomposition:
- Package seven_seg_pkg holds:
  - the state enum (IDLE, BLANK, DRIVE);
  - the 16-entry SEG_CODE constant array;
  - the SEG_OFF constant;
  - a width helper function for digit_idx.
- Sub-module hex_to_seg7: combinational nibble-to-7-segment decoder with polarity parameter. It is instantiated once, on the muxed current nibble.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, ACTIVE_LOW=1):
- Reset then enable=1, no value written:
  - each slot shows 2 cycles with digit_sel=1111 and seg_out=7F, then 6 cycles with digit_sel=1110, 1101, 1011, 0111 in turn and seg_out=40 ("0");
  - frame_done pulses every 32 cycles.
- value_in=16'h12AF with value_valid mid-frame:
  - the current frame still shows 0000;
  - the next frame shows digit0 seg_out=0E (F), digit1=08 (A), digit2=24 (2), digit3=79 (1).
- value_valid asserted on the frame_done cycle with value_in=16'h0007: the next frame shows 7 (seg_out=78) on digit0 with no one-frame delay.
- lz_suppress=1, value=16'h0050, dp_in=4'b0100:
  - digit3: seg_out=7F, dp_out=1;
  - digit2: seg_out=7F, dp_out=0;
  - digit1: seg_out=12 (5);
  - digit0: seg_out=40.
- enable dropped during a digit2 DRIVE slot: the next cycle all outputs are OFF and digit_idx=0. Re-enable restarts at a digit0 BLANK slot.
- Async reset asserted mid-DRIVE, between clock edges: outputs go OFF immediately; after release the display and shadow read 0.
